// File: rtl/nx_node_core_lut.sv
// Node compute core: runs a loaded program of 3-input LUT instructions once per tick.
// Optional NX_NODE_OUT_DIFF_EN: out_valids reports only outputs whose value changed this pass.
module nx_node_core_lut #(
    parameter int unsigned REG_W = 32,
    parameter int unsigned IO_W  = 8,
    parameter int unsigned SLOTS = 64,
    localparam int unsigned INST_W = 8 + 4 * $clog2(REG_W) + 1 + $clog2(IO_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     stall,
    output logic                     in_setup,
    output logic                     in_wait,
    output logic                     in_run,
    input  logic [INST_W-1:0]        load_instr,
    input  logic [$clog2(SLOTS)-1:0] load_slot,
    input  logic                     load_last,
    input  logic                     load_valid,
    input  logic                     in_value,
    input  logic [$clog2(IO_W)-1:0]  in_index,
    input  logic                     in_valid,
    output logic [IO_W-1:0]          out_values,
    output logic [IO_W-1:0]          out_valids,
    output logic                     done,
    output logic                     overrun
);

    localparam int unsigned RA_W  = $clog2(REG_W);
    localparam int unsigned OI_W  = $clog2(IO_W);
    localparam int unsigned SL_W  = $clog2(SLOTS);
    localparam int unsigned CNT_W = SL_W + 1;

    typedef enum logic [1:0] {StSetup, StWait, StRun} state_e;

    state_e              state;
    logic [INST_W-1:0]   store [SLOTS];
    logic [REG_W-1:0]    regs;
    logic [IO_W-1:0]     inputs;
    logic [SL_W-1:0]     step;
    logic [CNT_W-1:0]    count;
    logic [IO_W-1:0]     pass_mask;
`ifdef NX_NODE_OUT_DIFF_EN
    logic [IO_W-1:0]     start_vals;
`endif

    // Decoded fields of the current instruction, LSB-first: OUT_IDX, GEN_OUT, TGT, C, B, A, LUT
    logic [INST_W-1:0]   inst;
    logic [7:0]          lut;
    logic [RA_W-1:0]     src_a, src_b, src_c, tgt;
    logic                gen_out;
    logic [OI_W-1:0]     out_idx;
    logic                result;
    logic                last_step;
    logic [IO_W-1:0]     out_next;
    logic [IO_W-1:0]     mask_next;
    logic [IO_W-1:0]     valid_next;

    always_comb begin
        inst      = store[step];
        out_idx   = inst[OI_W-1:0];
        gen_out   = inst[OI_W];
        tgt       = inst[OI_W+1 +: RA_W];
        src_c     = inst[OI_W+1+RA_W +: RA_W];
        src_b     = inst[OI_W+1+2*RA_W +: RA_W];
        src_a     = inst[OI_W+1+3*RA_W +: RA_W];
        lut       = inst[OI_W+1+4*RA_W +: 8];
        result    = lut[{regs[src_a], regs[src_b], regs[src_c]}];
        last_step = ({1'b0, step} == count - CNT_W'(1));
        out_next  = out_values;
        mask_next = pass_mask;
        if (gen_out) begin
            out_next[out_idx]  = result;
            mask_next[out_idx] = 1'b1;
        end
`ifdef NX_NODE_OUT_DIFF_EN
        valid_next = mask_next & (out_next ^ start_vals);
`else
        valid_next = mask_next;
`endif
    end

    assign in_setup = (state == StSetup);
    assign in_wait  = (state == StWait);
    assign in_run   = (state == StRun);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StSetup;
            for (int i = 0; i < int'(SLOTS); i++) store[i] <= '0;
            regs       <= '0;
            inputs     <= '0;
            step       <= '0;
            count      <= '0;
            pass_mask  <= '0;
`ifdef NX_NODE_OUT_DIFF_EN
            start_vals <= '0;
`endif
            out_values <= '0;
            out_valids <= '0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valids <= '0;
            done       <= 1'b0;
            // Input writes land after this edge, so a coincident tick sees the old value
            if (in_valid) inputs[in_index] <= in_value;
            case (state)
                StSetup: begin
                    if (load_valid) begin
                        store[load_slot] <= load_instr;
                        if (load_last) begin
                            count <= CNT_W'(load_slot) + CNT_W'(1);
                            state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (tick) begin
                        regs[IO_W-1:0] <= inputs;
                        step           <= '0;
                        pass_mask      <= '0;
`ifdef NX_NODE_OUT_DIFF_EN
                        start_vals     <= out_values;
`endif
                        state          <= StRun;
                    end
                end
                StRun: begin
                    if (tick) overrun <= 1'b1;
                    if (!stall) begin
                        regs[tgt]  <= result;
                        out_values <= out_next;
                        pass_mask  <= mask_next;
                        if (last_step) begin
                            out_valids <= valid_next;
                            done       <= 1'b1;
                            state      <= StWait;
                        end else begin
                            step <= step + SL_W'(1);
                        end
                    end
                end
                default: state <= StSetup;
            endcase
        end
    end

endmodule

// File: tb/tb_nx_node_core_lut.sv
// Bench for nx_node_core_lut: table-driven passes with a result scoreboard plus
// hand-written sequences for overrun, same-cycle input writes and mid-run reset.
module tb_nx_node_core_lut;

`ifdef NX_NODE_OUT_DIFF_EN
    localparam bit DIFF = 1'b1;
`else
    localparam bit DIFF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        stall = 1'b0;
    logic        in_setup, in_wait, in_run;
    logic [31:0] load_instr = '0;
    logic [5:0]  load_slot = '0;
    logic        load_last = 1'b0;
    logic        load_valid = 1'b0;
    logic        in_value = 1'b0;
    logic [2:0]  in_index = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  out_values, out_valids;
    logic        done, overrun;

    nx_node_core_lut dut (
        .clk(clk), .rst(rst), .tick(tick), .stall(stall),
        .in_setup(in_setup), .in_wait(in_wait), .in_run(in_run),
        .load_instr(load_instr), .load_slot(load_slot), .load_last(load_last),
        .load_valid(load_valid), .in_value(in_value), .in_index(in_index),
        .in_valid(in_valid), .out_values(out_values), .out_valids(out_valids),
        .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vals;
        logic [7:0] valids;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] ins;
        int         stall_n;
        logic [7:0] vals;
    } vec_t;

    exp_t       sb[$];
    logic [7:0] model_prev = '0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] lut, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] c,
                                       input logic [4:0] t, input logic g, input logic [2:0] o);
        return {lut, a, b, c, t, g, o};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        model_prev = '0;
    endtask

    task automatic load(input logic [5:0] slot, input logic [31:0] instr, input logic last);
        load_valid = 1'b1;
        load_slot  = slot;
        load_instr = instr;
        load_last  = last;
        cyc();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic set_inputs(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_index = i[2:0];
            in_value = v[i];
            cyc();
        end
        in_valid = 1'b0;
    endtask

    // One pass: push expectation, tick, then watch (bounded) for done and compare.
    task automatic run_pass(input logic [7:0] mask, input logic [7:0] vals, input int lat,
                            input int stall_n, input int retick_at,
                            input bit cw_en, input int cw_idx, input bit cw_val);
        exp_t e;
        exp_t got;
        bit   seen;
        e.vals   = vals;
        e.valids = DIFF ? (mask & (vals ^ model_prev)) : mask;
        e.lat    = lat;
        sb.push_back(e);
        model_prev = vals;
        tick = 1'b1;
        if (cw_en) begin
            in_valid = 1'b1;
            in_index = cw_idx[2:0];
            in_value = cw_val;
        end
        cyc();
        tick = 1'b0;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            stall = (k <= stall_n);
            tick  = (k == retick_at);
            cyc();
            stall = 1'b0;
            tick  = 1'b0;
            if (done) begin
                seen = 1'b1;
                got = sb.pop_front();
                chk("latency", k, got.lat);
                chk("out_values", {24'h0, out_values}, {24'h0, got.vals});
                chk("out_valids", {24'h0, out_valids}, {24'h0, got.valids});
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
            got = sb.pop_front();
        end
        cyc();
        chk("done_width", {31'h0, done}, 32'h0);
        chk("valids_clear", {24'h0, out_valids}, 32'h0);
        chk("back_in_wait", {31'h0, in_wait}, 32'h1);
    endtask

    vec_t vecs[6];
    int   ndone;

    initial begin
        // Program A: r8 = r0 & r1; r9 = r8 ^ r2 -> out0
        vecs[0] = '{ins: 8'h03, stall_n: 0, vals: 8'h01};
        vecs[1] = '{ins: 8'h07, stall_n: 4, vals: 8'h00};
        vecs[2] = '{ins: 8'h04, stall_n: 0, vals: 8'h01};
        vecs[3] = '{ins: 8'h00, stall_n: 2, vals: 8'h00};
        vecs[4] = '{ins: 8'h05, stall_n: 1, vals: 8'h01};
        vecs[5] = '{ins: 8'h06, stall_n: 0, vals: 8'h01};

        do_reset();
        chk("rst_in_setup", {31'h0, in_setup}, 32'h1);
        chk("rst_in_wait", {31'h0, in_wait}, 32'h0);
        chk("rst_in_run", {31'h0, in_run}, 32'h0);
        chk("rst_out_values", {24'h0, out_values}, 32'h0);
        chk("rst_out_valids", {24'h0, out_valids}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);

        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        chk("setup_tick_no_overrun", {31'h0, overrun}, 32'h0);
        chk("setup_tick_stays_setup", {31'h0, in_setup}, 32'h1);

        load(6'd0, mk(8'hC0, 5'd0, 5'd1, 5'd0, 5'd8, 1'b0, 3'd0), 1'b0);
        chk("load_not_last_setup", {31'h0, in_setup}, 32'h1);
        load(6'd1, mk(8'h3C, 5'd8, 5'd2, 5'd0, 5'd9, 1'b1, 3'd0), 1'b1);
        chk("load_last_to_wait", {31'h0, in_wait}, 32'h1);

        for (int i = 0; i < 6; i++) begin
            set_inputs(vecs[i].ins);
            run_pass(8'h01, vecs[i].vals, 2 + vecs[i].stall_n, vecs[i].stall_n, 0, 1'b0, 0, 1'b0);
        end

        // Tick during RUN: flagged, ignored, pass completes on time
        set_inputs(8'h03);
        run_pass(8'h01, 8'h01, 2, 0, 1, 1'b0, 0, 1'b0);
        chk("overrun_set", {31'h0, overrun}, 32'h1);
        set_inputs(8'h07);
        run_pass(8'h01, 8'h00, 2, 0, 0, 1'b0, 0, 1'b0);
        chk("overrun_sticky", {31'h0, overrun}, 32'h1);

        // Input write coincident with tick is seen only by the following tick
        set_inputs(8'h03);
        run_pass(8'h01, 8'h01, 2, 0, 0, 1'b1, 2, 1'b1);
        run_pass(8'h01, 8'h00, 2, 0, 0, 1'b0, 0, 1'b0);

        // Single-instruction program: out7 = ~r3
        do_reset();
        chk("rst_clears_overrun", {31'h0, overrun}, 32'h0);
        load(6'd0, mk(8'h0F, 5'd3, 5'd0, 5'd0, 5'd10, 1'b1, 3'd7), 1'b1);
        set_inputs(8'h00);
        run_pass(8'h80, 8'h80, 1, 0, 0, 1'b0, 0, 1'b0);
        run_pass(8'h80, 8'h80, 1, 0, 0, 1'b0, 0, 1'b0);
        set_inputs(8'h08);
        run_pass(8'h80, 8'h00, 1, 0, 0, 1'b0, 0, 1'b0);

        // Four-instruction program, aborted by reset mid-run
        do_reset();
        load(6'd0, mk(8'hC0, 5'd0, 5'd1, 5'd0, 5'd8, 1'b0, 3'd0), 1'b0);
        load(6'd1, mk(8'h3C, 5'd8, 5'd2, 5'd0, 5'd9, 1'b1, 3'd0), 1'b0);
        load(6'd2, mk(8'h0F, 5'd9, 5'd0, 5'd0, 5'd10, 1'b1, 3'd1), 1'b0);
        load(6'd3, mk(8'hF0, 5'd10, 5'd0, 5'd0, 5'd11, 1'b1, 3'd2), 1'b1);
        set_inputs(8'h03);
        tick = 1'b1;
        cyc();
        chk("run_entered", {31'h0, in_run}, 32'h1);
        cyc();
        tick = 1'b0;
        chk("abort_overrun_set", {31'h0, overrun}, 32'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_prev = '0;
        chk("abort_in_setup", {31'h0, in_setup}, 32'h1);
        chk("abort_out_valids", {24'h0, out_valids}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_overrun", {31'h0, overrun}, 32'h0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (done || out_valids != 8'h00) ndone++;
        end
        chk("abort_no_emit", ndone, 0);

        load(6'd0, mk(8'hC0, 5'd0, 5'd1, 5'd0, 5'd8, 1'b0, 3'd0), 1'b0);
        load(6'd1, mk(8'h3C, 5'd8, 5'd2, 5'd0, 5'd9, 1'b1, 3'd0), 1'b0);
        load(6'd2, mk(8'h0F, 5'd9, 5'd0, 5'd0, 5'd10, 1'b1, 3'd1), 1'b0);
        load(6'd3, mk(8'hF0, 5'd10, 5'd0, 5'd0, 5'd11, 1'b1, 3'd2), 1'b1);
        load(6'd0, mk(8'h00, 5'd0, 5'd0, 5'd0, 5'd8, 1'b0, 3'd0), 1'b0);
        chk("wait_load_ignored_state", {31'h0, in_wait}, 32'h1);
        set_inputs(8'h03);
        run_pass(8'h07, 8'h01, 4, 0, 0, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
